// File: rtl/reservoir_ctrl.sv
// Commanded fill/full/drain sequencer for a 13-LED reservoir display.
// LED[11:0] is a thermometer of the level; LED[12] blinks while full.
module reservoir_ctrl #(
   parameter int unsigned TICK_DIV  = 25_000_000,
   parameter int unsigned BLINK_DIV = 50_000_000
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        start,
   input  logic        drain,
   output logic [12:0] LED,
   output logic [3:0]  level,
   output logic        full,
   output logic        busy
);

   localparam logic [27:0] TickLast  = 28'(TICK_DIV - 1);
   localparam logic [27:0] BlinkLast = 28'(BLINK_DIV - 1);
   localparam logic [3:0]  LevelMax  = 4'd12;

   typedef enum logic [1:0] {StIdle, StFill, StFull, StDrain} state_e;

   state_e      state_q, state_d;
   logic [3:0]  level_q, level_d;
   logic [27:0] tick_cnt_q, tick_cnt_d;
   logic [27:0] blink_cnt_q, blink_cnt_d;
   logic        blink_q, blink_d;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= StIdle;
         level_q     <= '0;
         tick_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         tick_cnt_q  <= tick_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      tick_cnt_d  = tick_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;

      unique case (state_q)
         StIdle: begin
            level_d = '0;
            if (start && !drain) state_d = StFill;
         end
         StFill: begin
            // A command in the same cycle as a tick wins; level holds.
            if (drain) begin
               state_d = StDrain;
            end else if (tick_cnt_q == TickLast) begin
               tick_cnt_d = '0;
               if (level_q < LevelMax) level_d = level_q + 4'd1;
               if (level_q >= LevelMax - 4'd1) state_d = StFull;
            end else begin
               tick_cnt_d = tick_cnt_q + 28'd1;
            end
         end
         StFull: begin
            level_d = LevelMax;
            if (drain) begin
               state_d = StDrain;
            end else if (blink_cnt_q == BlinkLast) begin
               blink_cnt_d = '0;
               blink_d     = ~blink_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 28'd1;
            end
         end
         StDrain: begin
            // drain has priority over start, and drain is a no-op here.
            if (start && !drain) begin
               state_d = StFill;
            end else if (tick_cnt_q == TickLast) begin
               tick_cnt_d = '0;
               if (level_q != 4'd0) level_d = level_q - 4'd1;
               if (level_q <= 4'd1) state_d = StIdle;
            end else begin
               tick_cnt_d = tick_cnt_q + 28'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) begin
         tick_cnt_d  = '0;
         blink_cnt_d = '0;
         blink_d     = (state_d == StFull);
      end
   end

   always_comb begin
      for (int i = 0; i < 12; i++) begin
         LED[i] = (4'(i) < level_q);
      end
      LED[12] = blink_q;
   end

   assign level = level_q;
   assign full  = (state_q == StFull);
   assign busy  = (state_q == StFill) || (state_q == StDrain);

endmodule

// File: tb/tb_reservoir_ctrl.sv
// Directed bench for reservoir_ctrl with TICK_DIV=4, BLINK_DIV=3.
module tb_reservoir_ctrl;

   logic        CLOCK;
   logic        RESET;
   logic        start;
   logic        drain;
   logic [12:0] LED;
   logic [3:0]  level;
   logic        full;
   logic        busy;

   int unsigned total;
   int unsigned passed;

   reservoir_ctrl #(
      .TICK_DIV  (4),
      .BLINK_DIV (3)
   ) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .start (start),
      .drain (drain),
      .LED   (LED),
      .level (level),
      .full  (full),
      .busy  (busy)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic wait_edges(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse(input logic s, input logic d);
      start = s;
      drain = d;
      tick();
      start = 1'b0;
      drain = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input logic [12:0] e_led, input logic [3:0] e_lvl,
                            input logic e_full, input logic e_busy);
      check({tag, ".led"},   32'(LED),   32'(e_led));
      check({tag, ".level"}, 32'(level), 32'(e_lvl));
      check({tag, ".full"},  32'(full),  32'(e_full));
      check({tag, ".busy"},  32'(busy),  32'(e_busy));
   endtask

   initial begin
      total  = 0;
      passed = 0;
      RESET  = 1'b1;
      start  = 1'b0;
      drain  = 1'b0;

      // Reset and idle
      for (int r = 0; r < 3; r++) begin
         tick();
         check_all("reset", 13'h0000, 4'd0, 1'b0, 1'b0);
      end
      RESET = 1'b0;
      pulse(1'b0, 1'b1);
      check_all("idle_drain", 13'h0000, 4'd0, 1'b0, 1'b0);
      wait_edges(3);
      check_all("idle_hold", 13'h0000, 4'd0, 1'b0, 1'b0);

      // Full fill: start sampled at edge 0
      pulse(1'b1, 1'b0);
      check_all("fill_e0", 13'h0000, 4'd0, 1'b0, 1'b1);
      wait_edges(3);
      check("fill_e3.level", 32'(level), 32'd0);
      wait_edges(1);
      check_all("fill_e4", 13'h0001, 4'd1, 1'b0, 1'b1);
      wait_edges(43);
      check_all("fill_e47", 13'h07FF, 4'd11, 1'b0, 1'b1);
      wait_edges(1);
      check_all("fill_e48", 13'h1FFF, 4'd12, 1'b1, 1'b0);
      wait_edges(2);
      check("blink_e50", 32'(LED[12]), 32'd1);
      wait_edges(1);
      check("blink_e51", 32'(LED[12]), 32'd0);
      wait_edges(3);
      check("blink_e54", 32'(LED[12]), 32'd1);
      wait_edges(3);
      check("blink_e57", 32'(LED[12]), 32'd0);
      wait_edges(2);

      // Drain from full: drain sampled at edge 60
      pulse(1'b0, 1'b1);
      check_all("drain_e60", 13'h0FFF, 4'd12, 1'b0, 1'b1);
      wait_edges(3);
      check("drain_e63.level", 32'(level), 32'd12);
      wait_edges(1);
      check_all("drain_e64", 13'h07FF, 4'd11, 1'b0, 1'b1);
      wait_edges(43);
      check_all("drain_e107", 13'h0001, 4'd1, 1'b0, 1'b1);
      wait_edges(1);
      check_all("drain_e108", 13'h0000, 4'd0, 1'b0, 1'b0);

      // Reversal: drain at level 5 runs down to 0
      pulse(1'b1, 1'b0);
      wait_edges(20);
      check("rev_fill5.level", 32'(level), 32'd5);
      pulse(1'b0, 1'b1);
      check_all("rev_drain5", 13'h001F, 4'd5, 1'b0, 1'b1);
      wait_edges(20);
      check_all("rev_empty", 13'h0000, 4'd0, 1'b0, 1'b0);

      // Reversal: start during drain at level 3 climbs to full
      pulse(1'b1, 1'b0);
      wait_edges(20);
      pulse(1'b0, 1'b1);
      wait_edges(8);
      check_all("rev_at3", 13'h0007, 4'd3, 1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      check_all("rev_refill", 13'h0007, 4'd3, 1'b0, 1'b1);
      wait_edges(35);
      check_all("rev_pre_full", 13'h07FF, 4'd11, 1'b0, 1'b1);
      wait_edges(1);
      check_all("rev_full", 13'h1FFF, 4'd12, 1'b1, 1'b0);

      // Reset while FULL
      wait_edges(1);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check_all("rst_full", 13'h0000, 4'd0, 1'b0, 1'b0);

      // Simultaneous commands in FILL at level 7
      pulse(1'b1, 1'b0);
      wait_edges(28);
      check("sim_fill7.level", 32'(level), 32'd7);
      pulse(1'b1, 1'b1);
      check_all("sim_fill", 13'h007F, 4'd7, 1'b0, 1'b1);
      wait_edges(3);
      check("sim_hold7.level", 32'(level), 32'd7);
      wait_edges(1);
      check_all("sim_dec6", 13'h003F, 4'd6, 1'b0, 1'b1);

      // Reset while FILL at level 6
      pulse(1'b1, 1'b0);
      check_all("fill_at6", 13'h003F, 4'd6, 1'b0, 1'b1);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check_all("rst_fill", 13'h0000, 4'd0, 1'b0, 1'b0);

      // Simultaneous commands in IDLE
      pulse(1'b1, 1'b1);
      check_all("sim_idle", 13'h0000, 4'd0, 1'b0, 1'b0);
      wait_edges(5);
      check_all("sim_idle_hold", 13'h0000, 4'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
